leiwand_rv32_wb_uart_tx: RTL
============================

// Module: leiwand_rv32_wb_uart_tx
// PURPOSE
//  Wishbone slave UART transmitter on the core's data/instruction bus, next to internal_sram/internal_rom.
//  Decoded by an external stb gate, e.g. stb && addr in [0x30000000, 0x30000010).
//  The core writes bytes into a small TX FIFO; an 8N1 serializer shifts them out on tx at a programmable rate.
//  The read-data output is OR-combined with the other slaves, so it is zero whenever no ack is being driven.
// PARAMETERS
//  MEM_WIDTH    32  bus address/data width
//  FIFO_DEPTH   8   TX FIFO entries; power of 2, >=2
//  DEFAULT_DIV  16  reset value of BAUD_DIV (clocks per UART bit)
// PORTS
//  clk              in   1          system clock, all logic on rising edge
//  reset            in   1          asynchronous, active-low reset
//  wb_addr          in   MEM_WIDTH  byte address; only [3:2] decoded
//  wb_data_in       in   MEM_WIDTH  write data from master
//  wb_data_out      out  MEM_WIDTH  read data to master; 0 unless wb_ack
//  wb_we            in   1          1 = write
//  wb_stb           in   1          strobe, pre-gated by address decode
//  wb_ack           out  1          one-cycle acknowledge
//  wb_cyc           in   1          bus cycle valid
//  wb_stall         out  1          tied 0
//  data_write_size  in   3          bytes written (1/2/4); only byte lane [7:0] used
//  tx               out  1          serial output, idle high
//  tx_empty_irq     out  1          1 when FIFO empty and serializer idle
// BEHAVIOUR
//  Reset (reset=0, async): tx=1, wb_ack=0, wb_data_out=0, FIFO empty, FSM IDLE,
//   BAUD_DIV=DEFAULT_DIV, overflow=0, tx_empty_irq=1.
//  Register map (addr[3:2]):
//   0 TXDATA   W: push wb_data_in[7:0]; R: 0
//   1 STATUS   R: [0] busy (FSM!=IDLE), [1] full, [2] empty, [3] overflow (sticky),
//                 [15:8] FIFO count; W: ignored
//   2 BAUD_DIV R/W: [15:0]; a write of 0 stores 1
//   3 reserved R: 0, W: ignored
//  Bus handshake:
//   - Access accepted on a cycle with wb_stb && wb_cyc and wb_ack currently 0.
//   - wb_ack=1 exactly one cycle later, with wb_data_out valid in that cycle only; 1-cycle latency.
//   - Back-to-back strobes are acked on alternate cycles; wb_stall is always 0.
//   - Write side effects (push, BAUD_DIV update) take place at the accept edge.
//   - An ack'd STATUS read clears overflow; an overflow set in the same cycle wins.
//  FIFO:
//   - Circular buffer; pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
//   - A push when full (full evaluated before any same-cycle pop) is dropped and sets overflow.
//   - Same-cycle push and pop with count in 1..DEPTH-1: count unchanged.
//  Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE/START.
//   - IDLE: tx=1. If FIFO not empty: pop, latch byte and BAUD_DIV, go to START.
//   - START: tx=0 for div clocks.
//   - DATA: 8 bits LSB first, div clocks each.
//   - STOP: tx=1 for div clocks. At the end, pop and go to START if FIFO not empty, else IDLE.
//   - Frame = 10*div clocks with no idle gap between queued bytes.
//   - A BAUD_DIV write during a frame affects only later frames.
//   - The bit counter is a 16-bit down-counter reloaded with div-1.
//  tx_empty_irq is registered from (next count==0 && next state==IDLE).
// TESTING
//  1 Reset: hold reset=0 mid-frame -> tx=1, STATUS reads 0x00000004, BAUD_DIV reads 16.
//  2 Write TXDATA=0x55 with div 16 -> tx low for 16 clk, then 1,0,1,0,1,0,1,0 (16 clk each),
//    then high; busy clears after 160 clk.
//  3 Write BAUD_DIV=0 -> reads back 1; queued 0xA5 frames in 10 clk.
//  4 Push 9 bytes with FIFO_DEPTH=8 while idle (first one pops) -> none dropped.
//    Push 10 quickly -> STATUS[3]=1; a second STATUS read shows [3]=0.
//  5 Two queued bytes -> second start bit begins the clock after the first stop bit ends; no gap.
//  6 Every bus access -> ack exactly 1 cycle after stb; wb_data_out==0 whenever ack==0;
//    a reserved-address read returns 0.

Source files
------------

// File: rtl/leiwand_rv32_wb_uart_tx.sv
// Wishbone slave 8N1 UART transmitter: bus writes fill a small TX FIFO,
// and the serializer shifts each byte out LSB first at BAUD_DIV clocks per bit.
module leiwand_rv32_wb_uart_tx #(
  parameter int MEM_WIDTH   = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MEM_WIDTH-1:0] wb_addr,
  input  logic [MEM_WIDTH-1:0] wb_data_in,
  output logic [MEM_WIDTH-1:0] wb_data_out,
  input  logic                 wb_we,
  input  logic                 wb_stb,
  output logic                 wb_ack,
  input  logic                 wb_cyc,
  output logic                 wb_stall,
  input  logic [2:0]           data_write_size,
  output logic                 tx,
  output logic                 tx_empty_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [AW:0]          count, count_nxt;
  logic [15:0]          baud_div, div_lat, div_lat_nxt, cnt, cnt_nxt;
  logic [7:0]           shreg, shreg_nxt;
  logic [2:0]           bit_idx, bit_nxt;
  logic [1:0]           state, state_nxt, reg_sel;
  logic                 overflow, accept, push, push_ok, pop, full, empty;
  logic [MEM_WIDTH-1:0] rdata;
  logic                 unused;

  // Only the low byte lane and address bits [3:2] carry meaning here.
  assign unused   = ^{data_write_size, wb_addr[MEM_WIDTH-1:4], wb_addr[1:0],
                      wb_data_in[MEM_WIDTH-1:16]};
  assign wb_stall = 1'b0;
  assign reg_sel  = wb_addr[3:2];
  assign accept   = wb_stb && wb_cyc && !wb_ack;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = accept && wb_we && (reg_sel == 2'd0);
  assign push_ok  = push && !full;

  always_comb begin
    rdata = '0;
    if (!wb_we) begin
      case (reg_sel)
        2'd1: begin
          rdata[0]    = (state != S_IDLE);
          rdata[1]    = full;
          rdata[2]    = empty;
          rdata[3]    = overflow;
          rdata[15:8] = 8'(count);
        end
        2'd2:    rdata[15:0] = baud_div;
        default: rdata = '0;
      endcase
    end
  end

  // Serializer next state; pop doubles as "load a new frame" from IDLE or end of STOP.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_nxt     = bit_idx;
    shreg_nxt   = shreg;
    div_lat_nxt = div_lat;
    pop         = 1'b0;
    case (state)
      S_IDLE: pop = !empty;
      S_START:
        if (cnt == 16'd0) begin
          state_nxt = S_DATA;
          cnt_nxt   = div_lat - 16'd1;
          bit_nxt   = 3'd0;
        end else cnt_nxt = cnt - 16'd1;
      S_DATA:
        if (cnt == 16'd0) begin
          cnt_nxt   = div_lat - 16'd1;
          shreg_nxt = {1'b0, shreg[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end else cnt_nxt = cnt - 16'd1;
      default:
        if (cnt == 16'd0) begin
          if (empty) state_nxt = S_IDLE;
          else       pop = 1'b1;
        end else cnt_nxt = cnt - 16'd1;
    endcase
    if (pop) begin
      state_nxt   = S_START;
      shreg_nxt   = mem[rptr];
      div_lat_nxt = baud_div;
      cnt_nxt     = baud_div - 16'd1;
    end
  end

  assign count_nxt = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk)
    if (push_ok) mem[wptr] <= wb_data_in[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_ack       <= 1'b0;
      wb_data_out  <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      baud_div     <= 16'(DEFAULT_DIV);
      overflow     <= 1'b0;
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      div_lat      <= 16'(DEFAULT_DIV);
      tx           <= 1'b1;
      tx_empty_irq <= 1'b1;
    end else begin
      wb_ack      <= accept;
      wb_data_out <= accept ? rdata : '0;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count <= count_nxt;
      if (accept && wb_we && reg_sel == 2'd2)
        baud_div <= (wb_data_in[15:0] == 16'd0) ? 16'd1 : wb_data_in[15:0];
      // A dropped push in the same cycle as a STATUS read keeps the flag set.
      if (push && full)                             overflow <= 1'b1;
      else if (accept && !wb_we && reg_sel == 2'd1) overflow <= 1'b0;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_idx      <= bit_nxt;
      shreg        <= shreg_nxt;
      div_lat      <= div_lat_nxt;
      tx           <= (state_nxt == S_START) ? 1'b0 :
                      (state_nxt == S_DATA)  ? shreg_nxt[0] : 1'b1;
      tx_empty_irq <= (count_nxt == '0) && (state_nxt == S_IDLE);
    end
  end
endmodule
